// File: rtl/noc_tb_pkg.sv
// Shared definitions for the NoC traffic generator/sink pair: FSM encoding,
// backpressure LFSR constants and a small pass/fail tag helper.
package noc_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } sink_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Four-character ASCII tag for status registers / on-chip debug readout.
  function automatic logic [31:0] pass_fail_tag(input logic p);
    return p ? "PASS" : "FAIL";
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with hold enable; shared by the traffic gen and sink.
module lfsr16
  import noc_tb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!reset)  state <= LFSR_SEED;
    else if (en) state <= lfsr_step(state);
  end

endmodule

// File: rtl/axis_traffic_sink.sv
// AXI-Stream sink: pseudo-random backpressure, incrementing-pattern checker,
// saturating beat/error counters, watchdog and run status.
module axis_traffic_sink
  import noc_tb_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    NUM_BEATS      = 16,
  parameter logic [DATA_WIDTH-1:0] SEED           = '0,
  parameter logic [3:0]            STALL_MASK     = 4'b0000,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter int                    CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  input  logic                  axis_tvalid,
  output logic                  axis_tready,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  done,
  output logic                  timeout,
  output logic                  pass
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;
  localparam logic [1:0] S_TMO  = ST_TIMEOUT;

  logic [1:0]            state, state_nxt;
  logic [CNT_WIDTH-1:0]  beat_idx, wdog;
  logic [DATA_WIDTH-1:0] expected;
  logic [15:0]           lfsr_q, lfsr_post;
  logic                  lfsr_en, xfer, mismatch, last_beat, wd_expire;

  assign xfer      = axis_tvalid && axis_tready && (state == S_RUN);
  assign mismatch  = axis_tdata != expected;
  assign last_beat = beat_idx == CNT_WIDTH'(NUM_BEATS - 1);
  assign wd_expire = wdog == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  assign pass      = done && (err_count == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enable) state_nxt = S_RUN;
      S_RUN: begin
        // a transfer on the expiry cycle beats the watchdog
        if (xfer && last_beat)      state_nxt = S_DONE;
        else if (!xfer && wd_expire) state_nxt = S_TMO;
      end
      S_DONE, S_TMO: if (!enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // tready is registered from the LFSR value it will hold after this edge
  assign lfsr_en   = state == S_RUN;
  assign lfsr_post = lfsr_en ? lfsr_step(lfsr_q) : lfsr_q;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .state (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      axis_tready    <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      beat_count     <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      beat_idx       <= '0;
      wdog           <= '0;
      expected       <= '0;
    end else begin
      state       <= state_nxt;
      axis_tready <= (state_nxt == S_RUN) && ((lfsr_post & {12'd0, STALL_MASK}) == 16'd0);
      done        <= state_nxt == S_DONE;
      timeout     <= state_nxt == S_TMO;
      if (state == S_IDLE && enable) begin
        beat_count     <= '0;
        err_count      <= '0;
        first_err_idx  <= '0;
        first_err_data <= '0;
        beat_idx       <= '0;
        wdog           <= '0;
        expected       <= SEED;
      end else if (state == S_RUN) begin
        if (xfer) begin
          wdog     <= '0;
          beat_idx <= beat_idx + CNT_WIDTH'(1);
          expected <= expected + DATA_WIDTH'(1);
          if (~&beat_count) beat_count <= beat_count + CNT_WIDTH'(1);
          if (mismatch) begin
            if (~&err_count) err_count <= err_count + CNT_WIDTH'(1);
            if (err_count == '0) begin
              first_err_idx  <= beat_idx;
              first_err_data <= axis_tdata;
            end
          end
        end else if (!wd_expire) begin
          wdog <= wdog + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_traffic_sink.sv
// Directed bench for axis_traffic_sink: three configurations, scoreboard of
// expected counter values per accepted beat.
module tb_axis_traffic_sink;

  localparam int ND = 3;

  logic        clk, reset;
  logic        enable [ND];
  logic        tvalid [ND];
  logic [63:0] tdata  [ND];
  logic        tready [ND];
  logic [31:0] beat_count [ND];
  logic [31:0] err_count  [ND];
  logic [31:0] first_err_idx [ND];
  logic [63:0] first_err_data [ND];
  logic        done [ND], timeout [ND], pass [ND];

  typedef struct { logic [31:0] cnt; logic [31:0] err; } exp_t;
  exp_t exp_q[$];

  int          n_cmp = 0, n_err = 0, stalls = 0;
  logic [31:0] m_idx, m_err;
  logic [63:0] m_seed;

  axis_traffic_sink #(.DATA_WIDTH(64), .NUM_BEATS(16), .SEED(64'd0),
    .STALL_MASK(4'h0), .TIMEOUT_CYCLES(8), .CNT_WIDTH(32)) u0 (
    .clk(clk), .reset(reset), .enable(enable[0]), .axis_tdata(tdata[0]),
    .axis_tvalid(tvalid[0]), .axis_tready(tready[0]), .beat_count(beat_count[0]),
    .err_count(err_count[0]), .first_err_idx(first_err_idx[0]),
    .first_err_data(first_err_data[0]), .done(done[0]), .timeout(timeout[0]), .pass(pass[0]));

  axis_traffic_sink #(.DATA_WIDTH(64), .NUM_BEATS(16), .SEED(64'd0),
    .STALL_MASK(4'hF), .TIMEOUT_CYCLES(1024), .CNT_WIDTH(32)) u1 (
    .clk(clk), .reset(reset), .enable(enable[1]), .axis_tdata(tdata[1]),
    .axis_tvalid(tvalid[1]), .axis_tready(tready[1]), .beat_count(beat_count[1]),
    .err_count(err_count[1]), .first_err_idx(first_err_idx[1]),
    .first_err_data(first_err_data[1]), .done(done[1]), .timeout(timeout[1]), .pass(pass[1]));

  axis_traffic_sink #(.DATA_WIDTH(64), .NUM_BEATS(4), .SEED(64'hFFFF_FFFF_FFFF_FFFE),
    .STALL_MASK(4'h0), .TIMEOUT_CYCLES(1024), .CNT_WIDTH(32)) u2 (
    .clk(clk), .reset(reset), .enable(enable[2]), .axis_tdata(tdata[2]),
    .axis_tvalid(tvalid[2]), .axis_tready(tready[2]), .beat_count(beat_count[2]),
    .err_count(err_count[2]), .first_err_idx(first_err_idx[2]),
    .first_err_data(first_err_data[2]), .done(done[2]), .timeout(timeout[2]), .pass(pass[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int d);
    check("rst_tready",  {63'd0, tready[d]},  64'd0);
    check("rst_beats",   {32'd0, beat_count[d]}, 64'd0);
    check("rst_errs",    {32'd0, err_count[d]},  64'd0);
    check("rst_eidx",    {32'd0, first_err_idx[d]}, 64'd0);
    check("rst_edata",   first_err_data[d], 64'd0);
    check("rst_done",    {63'd0, done[d]},    64'd0);
    check("rst_timeout", {63'd0, timeout[d]}, 64'd0);
    check("rst_pass",    {63'd0, pass[d]},    64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic start_run(input int d, input logic [63:0] seed);
    check("idle_tready", {63'd0, tready[d]}, 64'd0);
    m_seed = seed; m_idx = 0; m_err = 0; stalls = 0;
    enable[d] = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_beat(input int d, input logic [63:0] val);
    int   w;
    exp_t e;
    w = 0;
    tvalid[d] = 1'b1; tdata[d] = val;
    while (tready[d] !== 1'b1 && w < 3000) begin
      stalls++; @(negedge clk); w++;
    end
    check("tready_wait", {63'd0, tready[d]}, 64'd1);
    if (tready[d] === 1'b1) begin
      if (val !== m_seed + 64'(m_idx)) m_err++;
      m_idx++;
      exp_q.push_back('{cnt: m_idx, err: m_err});
      @(negedge clk);
      e = exp_q.pop_front();
      check("beat_count", {32'd0, beat_count[d]}, {32'd0, e.cnt});
      check("err_count",  {32'd0, err_count[d]},  {32'd0, e.err});
    end
  endtask

  task automatic end_run(input int d);
    tvalid[d] = 1'b0; enable[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      enable[d] = 1'b0; tvalid[d] = 1'b0; tdata[d] = '0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) check_zero(d);
    reset = 1'b1;
    @(negedge clk);

    // ideal back-to-back stream
    start_run(0, 64'd0);
    for (int i = 0; i < 16; i++) send_beat(0, 64'(i));
    check("ideal_done",   {63'd0, done[0]},   64'd1);
    check("ideal_pass",   {63'd0, pass[0]},   64'd1);
    check("ideal_tready", {63'd0, tready[0]}, 64'd0);
    check("ideal_stalls", 64'(stalls), 64'd0);
    end_run(0);
    check("idle_done",  {63'd0, done[0]}, 64'd0);
    check("idle_hold",  {32'd0, beat_count[0]}, 64'd16);

    // single corrupted beat
    start_run(0, 64'd0);
    for (int i = 0; i < 16; i++) send_beat(0, (i == 5) ? 64'hDEAD : 64'(i));
    check("corr_errs",  {32'd0, err_count[0]}, 64'd1);
    check("corr_eidx",  {32'd0, first_err_idx[0]}, 64'd5);
    check("corr_edata", first_err_data[0], 64'hDEAD);
    check("corr_done",  {63'd0, done[0]}, 64'd1);
    check("corr_pass",  {63'd0, pass[0]}, 64'd0);
    end_run(0);

    // watchdog: 3 beats then silence, TIMEOUT_CYCLES=8
    start_run(0, 64'd0);
    for (int i = 0; i < 3; i++) send_beat(0, 64'(i));
    tvalid[0] = 1'b0;
    repeat (7) @(negedge clk);
    check("tmo_early", {63'd0, timeout[0]}, 64'd0);
    @(negedge clk);
    check("tmo_fire",  {63'd0, timeout[0]}, 64'd1);
    check("tmo_beats", {32'd0, beat_count[0]}, 64'd3);
    check("tmo_done",  {63'd0, done[0]}, 64'd0);
    check("tmo_tready", {63'd0, tready[0]}, 64'd0);
    end_run(0);

    // heavy backpressure, data held until accepted
    start_run(1, 64'd0);
    for (int i = 0; i < 16; i++) send_beat(1, 64'(i));
    check("bp_stalls_seen", {63'd0, (stalls > 0)}, 64'd1);
    check("bp_beats", {32'd0, beat_count[1]}, 64'd16);
    check("bp_pass",  {63'd0, pass[1]}, 64'd1);
    check("bp_tready", {63'd0, tready[1]}, 64'd0);
    end_run(1);

    // expected-value wrap past 2^64
    start_run(2, 64'hFFFF_FFFF_FFFF_FFFE);
    send_beat(2, 64'hFFFF_FFFF_FFFF_FFFE);
    send_beat(2, 64'hFFFF_FFFF_FFFF_FFFF);
    send_beat(2, 64'h0);
    send_beat(2, 64'h1);
    check("wrap_pass", {63'd0, pass[2]}, 64'd1);
    end_run(2);

    // reset in the middle of a run, then a fresh run
    start_run(0, 64'd0);
    for (int i = 0; i < 7; i++) send_beat(0, 64'(i));
    tvalid[0] = 1'b1; tdata[0] = 64'd7;
    reset = 1'b0; enable[0] = 1'b0;
    @(negedge clk);
    check_zero(0);
    tvalid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    start_run(0, 64'd0);
    for (int i = 0; i < 16; i++) send_beat(0, 64'(i));
    check("rerun_beats", {32'd0, beat_count[0]}, 64'd16);
    check("rerun_pass",  {63'd0, pass[0]}, 64'd1);
    end_run(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
